// File: rtl/fetch_queue.sv
// fetch_queue: PC owner and instruction-fetch FIFO feeding decode over valid/ready.
// Define FETCH_STATS_EN to add the stat_fetched/stat_flushed counters.
module fetch_queue #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_instr,
    output logic [PC_W-1:0] id_pc,
    output logic [6:0]      id_opcode
`ifdef FETCH_STATS_EN
   ,output logic [31:0]     stat_fetched,
    output logic [31:0]     stat_flushed
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [PC_W-1:0] ALIGN = ~PC_W'(3);

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
    logic [31:0]     instr_q [DEPTH];
    logic [PC_W-1:0] fpc_q [DEPTH];
    logic [AW-1:0]   rd_q, wr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            issue, push, pop;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        issue    = 1'b0;
        push     = 1'b0;
        pop      = id_valid & id_ready;
        case (state_q)
            IDLE:    issue = !redirect_valid && count_q < FULL;
            WAIT:    begin
                push    = imem_rvalid && !redirect_valid;
                state_d = imem_rvalid ? IDLE : redirect_valid ? DRAIN : WAIT;
            end
            // a redirect landing on the stale response itself must not wait for another
            DRAIN:   state_d = imem_rvalid ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
        if (issue) begin
            pc_d     = pc_q + PC_W'(4);
            req_pc_d = pc_q;
            state_d  = WAIT;
        end
        if (redirect_valid)
            pc_d = redirect_pc & ALIGN;
        count_d = redirect_valid ? '0 : count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC & ALIGN;
            req_pc_q <= '0;
            rd_q     <= '0;
            wr_q     <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            rd_q     <= redirect_valid ? '0 : rd_q + AW'(pop);
            wr_q     <= redirect_valid ? '0 : wr_q + AW'(push);
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr_q] <= imem_rdata;
            fpc_q[wr_q]   <= req_pc_q;
        end
    end

    assign imem_req  = issue && !reset;
    assign imem_addr = pc_q & ALIGN;
    assign id_valid  = count_q != '0;
    assign id_instr  = id_valid ? instr_q[rd_q] : NOP;
    assign id_pc     = id_valid ? fpc_q[rd_q] : '0;
    assign id_opcode = id_instr[6:0];

`ifdef FETCH_STATS_EN
    logic [31:0] fetched_q, flushed_q;
    logic        drop_rsp;

    assign drop_rsp = imem_rvalid && ((state_q == WAIT && redirect_valid) || state_q == DRAIN);

    always_ff @(posedge clk) begin
        if (reset) begin
            fetched_q <= '0;
            flushed_q <= '0;
        end else begin
            fetched_q <= fetched_q + 32'(push);
            // an entry popped in the redirect cycle belongs to decode, not the flush
            flushed_q <= flushed_q + 32'(redirect_valid ? count_q - CW'(pop) : CW'(0)) + 32'(drop_rsp);
        end
    end

    assign stat_fetched = fetched_q;
    assign stat_flushed = flushed_q;
`endif
endmodule
